// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit between the PC register and the
//            instruction memory port. Issues in-order fetch requests for the
//            current PC over a valid/ready port. Tags each returning
//            instruction with the PC it was fetched from. Buffers the tagged
//            results for decode. Holds the PC register whenever no request is
//            accepted. Flushes buffered and in-flight fetches on a jump.
// Ports    :
//   clk, rst_n          clock; asynchronous active-low reset
//   pc_i                current PC from the PC register
//   jump_flag_i         redirect; the PC register loads the target this edge
//   hold_o              hold to the PC register (1 keeps PC)
//   req_valid_o/ready_i fetch request handshake, req_addr_o = pc_i
//   rsp_valid_i/data_i  in-order memory response, always accepted
//   inst_valid_o/ready_i decode handshake
//   inst_o, inst_pc_o   head instruction and its PC
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    output logic        hold_o,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    // PCs of accepted requests, waiting for their responses
    logic [31:0]      pend_mem [DEPTH];
    logic [PTR_W-1:0] pend_wr;
    logic [PTR_W-1:0] pend_rd;

    // Tagged instructions waiting for decode
    logic [31:0]      data_pc_mem   [DEPTH];
    logic [31:0]      data_inst_mem [DEPTH];
    logic [PTR_W-1:0] data_wr;
    logic [PTR_W-1:0] data_rd;
    logic [CNT_W-1:0] data_count;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;

    // Last head presented to decode, shown while the buffer is empty
    logic [31:0]      last_inst;
    logic [31:0]      last_pc;

    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             data_push;
    logic             data_pop;

    // Credit covers every in-flight request, including ones that will be
    // discarded, so buffer space always exists when a response returns.
    assign credit_used  = {1'b0, outstanding} + {1'b0, data_count};
    assign req_valid_o  = rst_n & ~jump_flag_i & (credit_used < CREDIT_MAX);
    assign req_fire     = req_valid_o & req_ready_i;
    assign req_addr_o   = pc_i;

    // PC advances only on an accepted fetch; never held during a jump so the
    // PC register can load the redirect target.
    assign hold_o       = ~req_fire & ~jump_flag_i;

    // A response arriving in the jump cycle belongs to the old stream.
    assign data_push    = rsp_valid_i & (discard == '0) & ~jump_flag_i;
    assign inst_valid_o = (data_count != '0);
    assign data_pop     = inst_valid_o & inst_ready_i;

    assign inst_o    = inst_valid_o ? data_inst_mem[data_rd] : last_inst;
    assign inst_pc_o = inst_valid_o ? data_pc_mem[data_rd]   : last_pc;

    // Storage arrays; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pend_mem[pend_wr] <= pc_i;
        end
        if (data_push) begin
            data_pc_mem[data_wr]   <= pend_mem[pend_rd];
            data_inst_mem[data_wr] <= rsp_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_wr     <= '0;
            pend_rd     <= '0;
            data_wr     <= '0;
            data_rd     <= '0;
            data_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
            last_inst   <= '0;
            last_pc     <= '0;
        end else begin
            if (req_fire) begin
                pend_wr <= pend_wr + PTR_W'(1);
            end
            // Every response retires one pend entry, kept or dropped.
            if (rsp_valid_i) begin
                pend_rd <= pend_rd + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_valid_i);

            // On a jump every still-outstanding response is stale; one
            // arriving right now is already dropped and not counted again.
            if (jump_flag_i) begin
                discard <= outstanding - CNT_W'(rsp_valid_i);
            end else if (rsp_valid_i && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end

            if (jump_flag_i) begin
                data_wr    <= '0;
                data_rd    <= '0;
                data_count <= '0;
            end else begin
                if (data_push) begin
                    data_wr <= data_wr + PTR_W'(1);
                end
                if (data_pop) begin
                    data_rd <= data_rd + PTR_W'(1);
                end
                data_count <= data_count + CNT_W'(data_push) - CNT_W'(data_pop);
            end

            if (inst_valid_o) begin
                last_inst <= data_inst_mem[data_rd];
                last_pc   <= data_pc_mem[data_rd];
            end
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    a_rsp_without_req : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(rsp_valid_i && (outstanding == '0))
    );

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Directed self-checking bench for ifu_fetch. A DEPTH=2 instance
//            runs the directed scenarios against a PC-register model and an
//            in-order memory model with programmable latency. A DEPTH=4
//            instance streams with latency 1 and full readiness to show one
//            instruction per cycle. Memory returns ~address as the word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;

    // DEPTH=2 instance
    logic [31:0] pc;
    logic [31:0] target;
    logic        jump;
    logic        hold;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    // DEPTH=4 streaming instance
    logic [31:0] pc_b;
    logic        hold_b;
    logic        req_valid_b;
    logic [31:0] req_addr_b;
    logic        rsp_valid_b;
    logic [31:0] rsp_data_b;
    logic        inst_valid_b;
    logic [31:0] inst_b;
    logic [31:0] inst_pc_b;

    int          tests;
    int          fails;
    int          mem_lat;
    int          cyc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    ifu_fetch #(.DEPTH(2)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc),
        .jump_flag_i  (jump),
        .hold_o       (hold),
        .req_valid_o  (req_valid),
        .req_addr_o   (req_addr),
        .req_ready_i  (req_ready),
        .rsp_valid_i  (rsp_valid),
        .rsp_data_i   (rsp_data),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_ready_i (inst_ready)
    );

    ifu_fetch #(.DEPTH(4)) u_dut_stream (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_b),
        .jump_flag_i  (1'b0),
        .hold_o       (hold_b),
        .req_valid_o  (req_valid_b),
        .req_addr_o   (req_addr_b),
        .req_ready_i  (1'b1),
        .rsp_valid_i  (rsp_valid_b),
        .rsp_data_i   (rsp_data_b),
        .inst_valid_o (inst_valid_b),
        .inst_o       (inst_b),
        .inst_pc_o    (inst_pc_b),
        .inst_ready_i (1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register models
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc <= 32'h0;
        else if (jump)  pc <= target;
        else if (!hold) pc <= pc + 32'h4;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc_b <= 32'h0;
        else if (!hold_b) pc_b <= pc_b + 32'h4;
    end

    // In-order memory, fixed latency mem_lat (response sampled mem_lat edges
    // after acceptance), reset together with the fetch unit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            cyc = 0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            cyc = cyc + 1;
            if (rsp_valid) void'(mq.pop_front());
            if (req_valid && req_ready) mq.push_back('{req_addr, cyc + mem_lat});
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ~mq[0].addr;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Latency-1 memory for the always-ready streaming instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_b <= 1'b0;
            rsp_data_b  <= 32'h0;
        end else begin
            rsp_valid_b <= req_valid_b;
            rsp_data_b  <= ~req_addr_b;
        end
    end

    // Decode-side collector
    always @(posedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_ins.push_back(inst);
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        tests++;
        assert (obs === expd) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expd);
        tests++;
        assert (obs === expd) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expd);
        end
    endtask

    function automatic logic [31:0] got_pc_at(input int i);
        if (i < got_pc.size()) return got_pc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] got_ins_at(input int i);
        if (i < got_ins.size()) return got_ins[i];
        return 'x;
    endfunction

    // Reset mid-cycle, release on the next falling edge; the remainder of
    // that cycle is the first fetch cycle.
    task automatic do_reset();
        rst_n      = 1'b0;
        jump       = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        got_pc.delete();
        got_ins.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        jump       = 1'b0;
        target     = 32'h0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        mem_lat    = 1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk1 ("rst_req_valid",  req_valid,  1'b0);
        chk1 ("rst_hold",       hold,       1'b1);
        chk1 ("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst",       inst,       32'h0);
        chk32("rst_inst_pc",    inst_pc,    32'h0);

        // Streaming, L=1, all ready
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1 ("first_req_valid", req_valid, 1'b1);
        chk32("first_req_addr",  req_addr,  32'h0);
        chk1 ("b_hold0",         hold_b,    1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            #1;
            chk1("b_hold", hold_b, 1'b0);
            if (k >= 2) begin
                chk1 ("b_valid", inst_valid_b, 1'b1);
                chk32("b_pc",    inst_pc_b,    32'(4 * (k - 2)));
                chk32("b_inst",  inst_b,       ~32'(4 * (k - 2)));
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk32("stream_pc",   got_pc_at(i),  32'(4 * i));
            chk32("stream_inst", got_ins_at(i), ~32'(4 * i));
        end

        // Memory backpressure at PC 0x8
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && pc != 32'h8; i++) @(negedge clk);
        chk32("bp_reach_pc8", pc, 32'h8);
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1 ("bp_hold", hold, 1'b1);
            chk32("bp_pc",   pc,   32'h8);
            @(negedge clk);
        end
        req_ready = 1'b1;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 5; i++) chk32("bp_seq", got_pc_at(i), 32'(4 * i));

        // Decode stall fills both slots
        mem_lat = 1;
        do_reset();
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk1 ("stall_valid",     inst_valid, 1'b1);
        chk32("stall_head_pc",   inst_pc,    32'h0);
        chk32("stall_head_inst", inst,       ~32'h0);
        chk1 ("stall_req_valid", req_valid,  1'b0);
        chk1 ("stall_hold",      hold,       1'b1);
        chk32("stall_pc",        pc,         32'h8);
        inst_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk32("stall_seq0", got_pc_at(0), 32'h0);
        chk32("stall_seq1", got_pc_at(1), 32'h4);
        chk32("stall_seq2", got_pc_at(2), 32'h8);

        // Jump with two fetches in flight, L=3
        mem_lat = 3;
        do_reset();
        repeat (2) @(negedge clk);
        #1;
        chk32("jmp_pc_before", pc,        32'h8);
        chk1 ("jmp_full",      req_valid, 1'b0);
        jump   = 1'b1;
        target = 32'h100;
        #1;
        chk1("jmp_hold",   hold,      1'b0);
        chk1("jmp_no_req", req_valid, 1'b0);
        @(negedge clk);
        jump = 1'b0;
        repeat (12) @(negedge clk);
        chk32("jmp_first_pc",   got_pc_at(0),  32'h100);
        chk32("jmp_first_inst", got_ins_at(0), ~32'h100);
        chk32("jmp_second_pc",  got_pc_at(1),  32'h104);

        // Jump coincident with a response and a decode pop, L=1
        mem_lat = 1;
        do_reset();
        repeat (2) @(negedge clk);
        jump   = 1'b1;
        target = 32'h200;
        #1;
        chk1 ("co_valid",  inst_valid, 1'b1);
        chk32("co_headpc", inst_pc,    32'h0);
        chk1 ("co_hold",   hold,       1'b0);
        @(negedge clk);
        jump = 1'b0;
        #1;
        chk1 ("co_empty",     inst_valid, 1'b0);
        chk1 ("co_req_valid", req_valid,  1'b1);
        chk32("co_req_addr",  req_addr,   32'h200);
        repeat (8) @(negedge clk);
        chk32("co_seq0", got_pc_at(0), 32'h0);
        chk32("co_seq1", got_pc_at(1), 32'h200);
        chk32("co_seq2", got_pc_at(2), 32'h204);

        // Asynchronous reset mid-stream
        mem_lat = 1;
        do_reset();
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("areset_req_valid",  req_valid,  1'b0);
        chk1 ("areset_hold",       hold,       1'b1);
        chk1 ("areset_inst_valid", inst_valid, 1'b0);
        chk32("areset_inst",       inst,       32'h0);
        chk32("areset_inst_pc",    inst_pc,    32'h0);
        @(negedge clk);
        got_pc.delete();
        got_ins.delete();
        rst_n = 1'b1;
        #1;
        chk1 ("restart_req_valid", req_valid, 1'b1);
        chk32("restart_req_addr",  req_addr,  32'h0);
        repeat (8) @(negedge clk);
        chk32("restart_seq0", got_pc_at(0), 32'h0);
        chk32("restart_seq1", got_pc_at(1), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
